// File: rtl/conv_window_scanner.sv
// Snapshots a flat image on start and streams every KxK stride-1 window in
// raster order over a valid/ready handshake, pulsing done after the last one.
module conv_window_scanner #(
    parameter int IMG_W = 20,
    parameter int IMG_H = 15,
    parameter int PIX_W = 8,
    parameter int K     = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [0:IMG_W*IMG_H*PIX_W-1]   img,
    input  logic                           win_ready,
    output logic [0:K*K*PIX_W-1]           win,
    output logic                           win_valid,
    output logic [7:0]                     win_row,
    output logic [7:0]                     win_col,
    output logic                           win_last,
    output logic                           busy,
    output logic                           done
);

    localparam int IMG_BITS = IMG_W * IMG_H * PIX_W;
    localparam int WIN_BITS = K * K * PIX_W;
    localparam int SNAP_AW  = $clog2(IMG_BITS);
    localparam int WIN_AW   = $clog2(WIN_BITS);

    localparam logic [7:0] ROW_LAST = 8'(IMG_H - K);
    localparam logic [7:0] COL_LAST = 8'(IMG_W - K);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]          state;
    logic [0:IMG_BITS-1] snap;
    logic                at_last;

    assign at_last   = (win_row == ROW_LAST) && (win_col == COL_LAST);
    assign win_valid = (state == EMIT);
    assign win_last  = win_valid && at_last;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            snap    <= '0;
            win_row <= '0;
            win_col <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap    <= img;
                        win_row <= '0;
                        win_col <= '0;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        // row/col freeze on the final window so they stay visible after done
                        if (at_last) begin
                            state <= FIN;
                        end else if (win_col == COL_LAST) begin
                            win_col <= '0;
                            win_row <= win_row + 8'd1;
                        end else begin
                            win_col <= win_col + 8'd1;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Window is a pure selection from the snapshot, so it holds whenever row/col hold.
    always_comb begin
        logic [SNAP_AW-1:0] src;
        logic [WIN_AW-1:0]  dst;
        win = '0;
        src = '0;
        dst = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                src = SNAP_AW'(((32'(win_row) + i) * IMG_W + 32'(win_col) + j) * PIX_W);
                dst = WIN_AW'((i * K + j) * PIX_W);
                win[dst +: PIX_W] = snap[src +: PIX_W];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scanner.sv
// Randomized self-checking bench for conv_window_scanner against a pixel-array window model.
module tb_conv_window_scanner;

    localparam int IMG_W    = 20;
    localparam int IMG_H    = 15;
    localparam int PIX_W    = 8;
    localparam int K        = 3;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int IMG_BITS = NPIX * PIX_W;
    localparam int WIN_BITS = K * K * PIX_W;
    localparam int NWIN     = (IMG_H - K + 1) * (IMG_W - K + 1);
    localparam int RL       = IMG_H - K;
    localparam int CL       = IMG_W - K;

    localparam logic [0:WIN_BITS-1] FIRST_W = {8'd0, 8'd1, 8'd2, 8'd20, 8'd21, 8'd22, 8'd40, 8'd41, 8'd42};
    localparam logic [0:WIN_BITS-1] LAST_W  = {8'd1, 8'd2, 8'd3, 8'd21, 8'd22, 8'd23, 8'd41, 8'd42, 8'd43};
    localparam logic [0:WIN_BITS-1] STALL_W = {8'd5, 8'd6, 8'd7, 8'd25, 8'd26, 8'd27, 8'd45, 8'd46, 8'd47};
    localparam logic [0:WIN_BITS-1] WRAP_W  = {8'd20, 8'd21, 8'd22, 8'd40, 8'd41, 8'd42, 8'd60, 8'd61, 8'd62};

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [0:IMG_BITS-1] img = '0;
    logic                win_ready = 1'b0;
    logic [0:WIN_BITS-1] win;
    logic                win_valid, win_last, busy, done;
    logic [7:0]          win_row, win_col;

    logic                start_d = 1'b0;
    logic [0:71]         img_d = '0;
    logic                ready_d = 1'b0;
    logic [0:71]         win_d;
    logic                valid_d, last_d, busy_d, done_d;
    logic [7:0]          row_d, col_d;

    int vectors = 0;
    int miscompares = 0;

    logic [PIX_W-1:0] pic    [NPIX];
    logic [PIX_W-1:0] snap_m [NPIX];

    conv_window_scanner #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .img(img), .win_ready(win_ready),
        .win(win), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .win_last(win_last), .busy(busy), .done(done)
    );

    conv_window_scanner #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .K(3)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .img(img_d), .win_ready(ready_d),
        .win(win_d), .win_valid(valid_d), .win_row(row_d), .win_col(col_d),
        .win_last(last_d), .busy(busy_d), .done(done_d)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:IMG_BITS-1] pack_img();
        logic [0:IMG_BITS-1] v;
        for (int p = 0; p < NPIX; p++) v[p*PIX_W +: PIX_W] = pic[p];
        return v;
    endfunction

    // Expected window: pixel (r+i, c+j) of the image captured at start.
    function automatic logic [0:WIN_BITS-1] ref_win(input int r, input int c);
        logic [0:WIN_BITS-1] w;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*PIX_W +: PIX_W] = snap_m[(r+i)*IMG_W + c + j];
        return w;
    endfunction

    task automatic load_ramp();
        for (int p = 0; p < NPIX; p++) pic[p] = PIX_W'(p % 256);
        img = pack_img();
    endtask

    task automatic begin_scan();
        snap_m = pic;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; start_d = 1'b1; win_ready = 1'b0;
        load_ramp();
        tick(); tick();
        vectors++;
        if ({win_valid, busy, done, win_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: valid/busy/done/last=%b expected 0000", {win_valid, busy, done, win_last});
        end
        vectors++;
        if (win_row !== 8'd0 || win_col !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_rowcol: row=%0d col=%0d expected 0 0", win_row, win_col);
        end
        vectors++;
        if (win !== '0) begin
            miscompares++;
            $display("FAIL reset_win: win=%h expected 0", win);
        end
        rst = 1'b0; start = 1'b0; start_d = 1'b0;
        tick();
        vectors++;
        if ({busy, win_valid, busy_d, valid_d} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_wins_over_start: busy/valid/busy_d/valid_d=%b expected 0000", {busy, win_valid, busy_d, valid_d});
        end
    endtask

    task automatic test_basic();
        int er = 0, ec = 0, n = 0;
        logic [0:WIN_BITS-1] last_w = '0;
        load_ramp();
        win_ready = 1'b1;
        begin_scan();
        vectors++;
        if (win_valid !== 1'b1 || win_row !== 8'd0 || win_col !== 8'd0 || win !== FIRST_W) begin
            miscompares++;
            $display("FAIL basic_first: valid=%b row=%0d col=%0d win=%h expected 1 0 0 %h", win_valid, win_row, win_col, win, FIRST_W);
        end
        for (int cyc = 0; cyc < NWIN + 10 && win_valid === 1'b1 && er <= RL; cyc++) begin
            vectors++;
            if (win_row !== 8'(er) || win_col !== 8'(ec) || win !== ref_win(er, ec) || win_last !== (er == RL && ec == CL)) begin
                miscompares++;
                $display("FAIL basic_window: row=%0d col=%0d last=%b win=%h expected %0d %0d %b %h",
                         win_row, win_col, win_last, win, er, ec, (er == RL && ec == CL), ref_win(er, ec));
            end
            last_w = win;
            n++;
            if (ec == CL) begin ec = 0; er++; end else ec++;
            tick();
        end
        vectors++;
        if (n != NWIN) begin
            miscompares++;
            $display("FAIL basic_count: transfers=%0d expected %0d", n, NWIN);
        end
        vectors++;
        if (last_w !== LAST_W) begin
            miscompares++;
            $display("FAIL basic_last_window: win=%h expected %h", last_w, LAST_W);
        end
        vectors++;
        if ({done, busy, win_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL basic_done: done/busy/valid=%b expected 110", {done, busy, win_valid});
        end
        vectors++;
        if (win_row !== 8'(RL) || win_col !== 8'(CL)) begin
            miscompares++;
            $display("FAIL basic_final_rowcol: row=%0d col=%0d expected %0d %0d", win_row, win_col, RL, CL);
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_idle: done/busy=%b expected 00", {done, busy});
        end
        win_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int er = 0, ec = 0, n = 0, stall = 0, dones = 0;
        bit pend = 0, fin = 0;
        logic rdy;
        load_ramp();
        win_ready = 1'b0;
        begin_scan();
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (pend) begin
                vectors++;
                if (done !== 1'b1 || win_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_done_timing: done=%b valid=%b expected 1 0", done, win_valid);
                end
                pend = 0;
            end
            if (done === 1'b1) dones++;
            rdy = 1'($urandom_range(0, 1));
            if (win_valid === 1'b1) begin
                vectors++;
                if (er > RL) begin
                    miscompares++;
                    $display("FAIL bp_overrun: row=%0d col=%0d expected no window past %0d", win_row, win_col, NWIN);
                    fin = 1;
                end else if (win_row !== 8'(er) || win_col !== 8'(ec) || win !== ref_win(er, ec) || win_last !== (er == RL && ec == CL)) begin
                    miscompares++;
                    $display("FAIL bp_window: row=%0d col=%0d win=%h expected %0d %0d %h", win_row, win_col, win, er, ec, ref_win(er, ec));
                end
                if (er == 0 && ec == 5 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                    vectors++;
                    if (win !== STALL_W) begin
                        miscompares++;
                        $display("FAIL bp_stall_hold: win=%h expected %h", win, STALL_W);
                    end
                end
                if (rdy) begin
                    n++;
                    pend = (er == RL && ec == CL);
                    if (ec == CL) begin ec = 0; er++; end else ec++;
                end
            end else if (busy === 1'b0) begin
                fin = 1;
            end
            win_ready = rdy;
            tick();
        end
        win_ready = 1'b0;
        vectors++;
        if (!fin || n != NWIN || dones != 1 || stall != 5) begin
            miscompares++;
            $display("FAIL bp_summary: finished=%0d transfers=%0d dones=%0d stalls=%0d expected 1 %0d 1 5", fin, n, dones, stall, NWIN);
        end
    endtask

    task automatic test_row_wrap();
        load_ramp();
        win_ready = 1'b1;
        begin_scan();
        for (int cyc = 0; cyc < 30 && !(win_row === 8'd0 && win_col === 8'd17); cyc++) tick();
        vectors++;
        if (win_valid !== 1'b1 || win_row !== 8'd0 || win_col !== 8'd17) begin
            miscompares++;
            $display("FAIL wrap_reach: valid=%b row=%0d col=%0d expected 1 0 17", win_valid, win_row, win_col);
        end
        tick();
        vectors++;
        if (win_valid !== 1'b1 || win_row !== 8'd1 || win_col !== 8'd0 || win !== WRAP_W) begin
            miscompares++;
            $display("FAIL wrap_next: valid=%b row=%0d col=%0d win=%h expected 1 1 0 %h", win_valid, win_row, win_col, win, WRAP_W);
        end
        win_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_snapshot();
        int er = 0, ec = 0, n = 0, dones = 0;
        bit fin = 0, poked = 0;
        logic rdy;
        for (int p = 0; p < NPIX; p++) pic[p] = PIX_W'($urandom);
        img = pack_img();
        win_ready = 1'b0;
        begin_scan();
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            start = 1'b0;
            if (done === 1'b1) dones++;
            rdy = 1'($urandom_range(0, 1));
            if (win_valid === 1'b1) begin
                vectors++;
                if (er > RL) begin
                    miscompares++;
                    $display("FAIL snap_overrun: row=%0d col=%0d expected no window past %0d", win_row, win_col, NWIN);
                    fin = 1;
                end else if (win_row !== 8'(er) || win_col !== 8'(ec) || win !== ref_win(er, ec)) begin
                    miscompares++;
                    $display("FAIL snap_window: row=%0d col=%0d win=%h expected %0d %0d %h", win_row, win_col, win, er, ec, ref_win(er, ec));
                end
                if (er == 3 && ec == 4 && !poked) begin
                    img = '1;
                    start = 1'b1;
                    poked = 1;
                end
                if (rdy) begin
                    n++;
                    if (ec == CL) begin ec = 0; er++; end else ec++;
                end
            end else if (busy === 1'b0) begin
                fin = 1;
            end
            win_ready = rdy;
            tick();
        end
        start = 1'b0;
        win_ready = 1'b0;
        vectors++;
        if (!fin || !poked || n != NWIN || dones != 1) begin
            miscompares++;
            $display("FAIL snap_summary: finished=%0d poked=%0d transfers=%0d dones=%0d expected 1 1 %0d 1", fin, poked, n, dones, NWIN);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({busy, win_valid, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL snap_no_restart: busy/valid/done=%b expected 000", {busy, win_valid, done});
            end
        end
    endtask

    task automatic test_reset_midscan();
        load_ramp();
        win_ready = 1'b1;
        begin_scan();
        for (int cyc = 0; cyc < 300 && !(win_row === 8'd6 && win_col === 8'd9); cyc++) tick();
        vectors++;
        if (win_valid !== 1'b1 || win_row !== 8'd6 || win_col !== 8'd9) begin
            miscompares++;
            $display("FAIL midrst_reach: valid=%b row=%0d col=%0d expected 1 6 9", win_valid, win_row, win_col);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        win_ready = 1'b0;
        vectors++;
        if ({win_valid, busy, done} !== 3'b000 || win_row !== 8'd0 || win_col !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_state: valid/busy/done=%b row=%0d col=%0d expected 000 0 0", {win_valid, busy, done}, win_row, win_col);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({win_valid, busy, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL midrst_no_done: valid/busy/done=%b expected 000", {win_valid, busy, done});
            end
        end
    endtask

    task automatic test_degenerate();
        logic [0:71] exp_w;
        exp_w = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        img_d = exp_w;
        ready_d = 1'b1;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        vectors++;
        if (valid_d !== 1'b1 || last_d !== 1'b1 || row_d !== 8'd0 || col_d !== 8'd0 || win_d !== exp_w) begin
            miscompares++;
            $display("FAIL degen_window: valid=%b last=%b row=%0d col=%0d win=%h expected 1 1 0 0 %h", valid_d, last_d, row_d, col_d, win_d, exp_w);
        end
        tick();
        vectors++;
        if ({done_d, busy_d, valid_d} !== 3'b110) begin
            miscompares++;
            $display("FAIL degen_done: done/busy/valid=%b expected 110", {done_d, busy_d, valid_d});
        end
        tick();
        vectors++;
        if ({done_d, busy_d} !== 2'b00) begin
            miscompares++;
            $display("FAIL degen_idle: done/busy=%b expected 00", {done_d, busy_d});
        end
        ready_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_row_wrap();
        test_snapshot();
        test_reset_midscan();
        test_basic();
        test_degenerate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_scanner.md
Name: conv_window_scanner

Overview:
- Downstream consumer of the input-image memory.
- Holds the flat pixel vector after the 200-cycle load completes, and snapshots it on `start`.
- Streams every valid KxK window (stride 1, no padding) in raster order to the convolution stage over a valid/ready handshake.
- Pulses `done` once the final window is accepted.

Parameters:
IMG_W, 20, image width in pixels
IMG_H, 15, image height in pixels
PIX_W, 8, bits per pixel
K, 3, window side; requires K <= IMG_W and K <= IMG_H

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a scan; sampled only in IDLE
img  input  [0:IMG_W*IMG_H*PIX_W-1]  flat image; pixel p = row*IMG_W+col at img[p*PIX_W +: PIX_W] (lowest index = pixel MSB)
win_ready  input  1  consumer accepts window this cycle
win  output  [0:K*K*PIX_W-1]  window; element (i,j) at win[(i*K+j)*PIX_W +: PIX_W] = pixel (row+i, col+j)
win_valid  output  1  win/win_row/win_col/win_last valid
win_row  output  8  top-left row of current window
win_col  output  8  top-left column of current window
win_last  output  1  current window is the final one
busy  output  1  scan in progress (state != IDLE)
done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset (rst=1 at clk edge, any state):
  - state -> IDLE.
  - win, win_row, win_col = 0; win_valid, win_last, busy, done = 0.
  - The snapshot register is cleared.
  - Reset mid-scan aborts without a done pulse.
- States: IDLE, EMIT, FIN.
- IDLE:
  - On the edge where start=1: capture img into the internal snapshot register, set row=col=0, go to EMIT.
  - busy rises in the next cycle.
  - start=0: stay in IDLE, outputs hold their reset/idle values.
- EMIT:
  - win_valid=1.
  - First window is valid in the cycle after start is sampled (1-cycle latency).
  - win is formed combinationally from the snapshot and the registered row/col, or registered (implementer's choice), but must be stable and correct whenever win_valid=1.
- Handshake:
  - Transfer occurs on an edge where win_valid && win_ready.
  - While win_valid && !win_ready: win, win_row, win_col and win_last hold unchanged for any number of cycles.
  - win_valid is never deasserted before a transfer.
- Advance on transfer:
  - If col < IMG_W-K: col+1.
  - Else col=0 and row+1.
  - The next window is presented in the very next cycle, so back-to-back transfers are allowed at 1 window/cycle.
- win_last = (row==IMG_H-K) && (col==IMG_W-K).
  - Transfer with win_last=1: go to FIN; win_valid=0 from the next cycle.
- FIN:
  - done=1 for exactly one cycle; busy=1 in FIN.
  - Next cycle: IDLE, busy=0.
  - win_row/win_col retain their final values until the next start.
- Total windows = (IMG_H-K+1)*(IMG_W-K+1); 234 with the defaults.
- start while busy (EMIT/FIN) is ignored: no restart, no recapture.
- img changes after capture do not affect the current scan.
- start sampled in the same cycle as rst=1: reset wins.
- Degenerate K=IMG_W=IMG_H: a single window with win_last=1.
- win_row/win_col are 8 bits wide, so IMG_W and IMG_H must be <= 256.
- No arithmetic on pixel values; pure selection.

Test Plan:
- Basic scan: img pixel p = p mod 256, pulse start one cycle, win_ready=1 constantly.
  - First window is valid 1 cycle later with row=0, col=0, values 0,1,2,20,21,22,40,41,42.
  - Exactly 234 transfers follow.
  - Last window: row=12, col=17, win_last=1, values 1,2,3,21,22,23,41,42,43.
  - done pulses exactly 1 cycle after the last transfer; busy falls the cycle after done.
- Backpressure: hold win_ready=0 for 5 cycles at window (0,5), toggle it randomly elsewhere.
  - win stays at 5,6,7,25,26,27,45,46,47 throughout the stall.
  - No window is skipped or duplicated; the sequence of (row,col) is strictly raster.
- Row wrap: at window (0,17), transfer, then check the next window.
  - Next window is row=1, col=0, values 20,21,22,40,41,42,60,61,62.
- Snapshot/ignore start: after start, overwrite img with all 0xFF and re-pulse start at window (3,4).
  - All windows still match the original image.
  - The count remains 234 with a single done pulse.
- Reset mid-scan: assert rst for 1 cycle at window (6,9).
  - Next cycle: win_valid=0, busy=0, done=0, win_row=win_col=0.
  - A new start then produces a full 234-window scan beginning at (0,0).
- Degenerate: parameters IMG_W=IMG_H=K=3, pixels 1..9.
  - A single window 1..9 with win_last=1, then done.
